// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Function : Sequential binary-to-BCD converter (shift-add-3 / double
//             dabble), one input bit per clock. Uses the divider's init/done
//             handshake so one control FSM can drive both blocks alike.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active-low
    input  logic                  init,
    input  logic [WIDTH-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done,
    output logic                  busy
);

    localparam int c_sw = 4*DIGITS + WIDTH;        // scratch width
    localparam int c_cw = $clog2(WIDTH + 1);       // shift counter width
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    // DIGITS decimal digits must hold the largest WIDTH-bit value.
    function automatic bit cfg_ok();
        longint unsigned lim;
        longint unsigned p;
        if (WIDTH < 1 || WIDTH > 56 || DIGITS < 1) return 1'b0;
        lim = (64'd1 << WIDTH) - 64'd1;
        p   = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 64'd10;
            if (p > lim) return 1'b1;
        end
        return 1'b0;
    endfunction

    if (!cfg_ok()) begin : g_cfg_err
        $fatal(1, "bin2bcd_seq: DIGITS=%0d cannot represent 2^%0d-1", DIGITS, WIDTH);
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_sw-1:0]     r_scratch;
    logic [c_cw-1:0]     r_count;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_done;
    logic                r_busy;

    logic [c_sw-1:0]     w_adj;
    logic [c_sw-1:0]     w_shifted;

    // Add 3 to every BCD digit that is 5 or more, then shift the whole
    // scratch left so the binary MSB enters the units digit.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[WIDTH + 4*d +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*d +: 4] = r_scratch[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj[c_sw-2:0], 1'b0};
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init) begin
                        r_scratch <= {{(4*DIGITS){1'b0}}, value};
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // init is deliberately ignored here: no restart, no queuing.
                    r_scratch <= w_shifted;
                    r_count   <= r_count + c_cw'(1);
                    if (r_count == c_last) begin
                        r_bcd   <= w_shifted[c_sw-1:WIDTH];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Function : Self-checking bench for bin2bcd_seq. Expected BCD results go
//             into a scoreboard queue when a conversion is started and are
//             popped when done rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        init;
    logic [15:0] value;
    logic [19:0] bcd;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] sb[$];
    logic        done_prev = 1'b0;

    typedef struct {
        logic [15:0] v;
        logic [19:0] exp;
    } vec_t;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .value (value),
        .bcd   (bcd),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("bcd_result", {12'd0, bcd}, {12'd0, sb.pop_front()});
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion with init held for 'hold' edges, optionally poking a
    // new value and a one-cycle init at cycle 'poke_at' of the conversion.
    task automatic run_conv(input logic [15:0] v, input logic [19:0] exp,
                            input int hold, input int poke_at,
                            input logic [15:0] poke_v);
        int lat;
        int busy_cyc;
        value = v;
        init  = 1'b1;
        sb.push_back(exp);
        tick();                          // accepting edge
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_done", {31'd0, done}, 32'd0);
        busy_cyc = 1;
        if (hold <= 1) init = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                value = poke_v;
                init  = 1'b1;
            end else if (lat == poke_at + 1) begin
                init = 1'b0;
            end
            tick();
            lat++;
            if (lat == hold - 1) init = 1'b0;
            if (busy) busy_cyc++;
        end
        init = 1'b0;
        check("latency", lat, 32'd16);
        check("busy_cycles", busy_cyc, 32'd16);
        check("done_busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_hold(input int n, input logic [19:0] exp);
        for (int i = 0; i < n; i++) tick();
        check("done_level_hold", {31'd0, done}, 32'd1);
        check("bcd_hold", {12'd0, bcd}, {12'd0, exp});
    endtask

    vec_t vecs[9];

    initial begin
        int rises;
        int t_first;
        int t_second;
        logic dp;
        int waitc;

        vecs[0] = '{16'hC86C, 20'h51308};
        vecs[1] = '{16'hFFFF, 20'h65535};
        vecs[2] = '{16'h0000, 20'h00000};
        vecs[3] = '{16'h0001, 20'h00001};
        vecs[4] = '{16'h0063, 20'h00099};
        vecs[5] = '{16'h270F, 20'h09999};
        vecs[6] = '{16'h2710, 20'h10000};
        vecs[7] = '{16'h8000, 20'h32768};
        vecs[8] = '{16'h1234, 20'h04660};

        reset = 1'b0;
        init  = 1'b0;
        value = 16'h0000;
        #23;
        check("reset_bcd",  {12'd0, bcd}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Two-cycle init pulse: exactly one conversion.
        run_conv(16'h00FE, 20'h00254, 2, -10, 16'h0000);
        idle_hold(20, 20'h00254);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].v, vecs[i].exp, 1, -10, 16'h0000);
            tick();
        end

        // init and value changes during SHIFT are ignored.
        run_conv(16'h0009, 20'h00009, 1, 5, 16'h1234);
        idle_hold(20, 20'h00009);
        run_conv(16'h1234, 20'h04660, 1, -10, 16'h0000);
        tick();

        // init held high for 40 cycles: accepts at cycles 1, 18 and 35.
        value = 16'h03E8;
        init  = 1'b1;
        sb.push_back(20'h01000);
        sb.push_back(20'h01000);
        sb.push_back(20'h01000);
        rises = 0; t_first = 0; t_second = 0; dp = done;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done && !dp) begin
                rises++;
                if (rises == 1) t_first = c;
                if (rises == 2) t_second = c;
            end
            dp = done;
        end
        init = 1'b0;
        check("held_init_rises", rises, 32'd2);
        check("held_init_spacing", t_second - t_first, 32'd17);
        check("held_init_bcd", {12'd0, bcd}, 32'h01000);
        waitc = 0;
        while (!(done && !dp) && waitc < 40) begin
            dp = done;
            tick();
            waitc++;
        end
        check("held_init_third_done", {31'd0, done}, 32'd1);
        tick();

        // Asynchronous reset in the middle of a conversion.
        value = 16'hC86C;
        init  = 1'b1;
        tick();
        init = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check("midreset_bcd",  {12'd0, bcd}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 25; c++) tick();
        check("post_reset_no_done", {31'd0, done}, 32'd0);
        run_conv(16'hC86C, 20'h51308, 1, -10, 16'h0000);
        tick();
        tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the 16-bit divider.
- Consumes the divider's 16-bit quotient field when the divider's done is seen, and produces packed BCD digits for the display/UART formatting path.
- Uses the same init/done handshake as the divider, so the control FSM drives both blocks identically.

Parameters:
- WIDTH, 16, bit width of the binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1.
- Any other combination is a configuration error, caught by a simulation-only check at time 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low. reset=0 immediately forces the reset state; released synchronously to clk by the system reset logic.
- init  in  1  start request; sampled on rising edge while idle.
- value  in  WIDTH  binary operand (divider quotient); captured on the accepting edge only.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- done  out  1  conversion complete / result valid.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bcd=0; done=0; busy=0; shift counter=0; internal scratch register=0.
  - Takes effect mid-conversion with no completion; done stays 0.
- States:
  - IDLE -> SHIFT on init=1 at the rising edge (accepting edge k).
  - SHIFT -> IDLE after WIDTH iterations.
  - No other states.
- Accepting edge k:
  - Scratch = {4*DIGITS zeros, value}; counter=0; busy=1; done=0.
  - bcd keeps its previous value.
- SHIFT, each edge:
  - In every BCD digit of scratch, if the digit is >= 5, add 3 (4-bit add, no carry between digits).
  - Then shift the whole scratch left 1 bit, with the value MSB entering digit 0 LSB.
  - Counter increments.
- Final iteration (counter=WIDTH-1, edge k+WIDTH):
  - bcd <= upper 4*DIGITS bits of the post-shift scratch.
  - done=1; busy=0; state=IDLE.
  - Latency: done and bcd valid after edge k+16 for WIDTH=16, i.e. 16 clocks after acceptance.
- done behaviour:
  - Level signal; stays 1 and bcd stays stable until the next accepted init, or reset.
  - The accepting edge clears done.
- init rules:
  - init=1 during SHIFT is ignored (no restart, no queuing).
  - init held high continuously: a new conversion is accepted on the first edge back in IDLE, i.e. the edge after done rises. done is then 1 for exactly one cycle per conversion.
  - init is level-sampled, not edge-detected. A 2-cycle init pulse started in IDLE yields a single conversion, because the second cycle falls in SHIFT.
- value is only required to be stable on the accepting edge; later changes have no effect.
- Boundary cases:
  - value=0 -> bcd=0.
  - value=2^WIDTH-1 converts exactly.
  - No overflow is possible, given the parameter constraint.
- busy and done are never 1 simultaneously.

Test Plan:
- Reset, then init=1 for 2 cycles with value=16'h00FE (quotient of 16'hC86C / 16'h00CA = 254):
  - done rises exactly 16 clocks after the accepting edge.
  - bcd=20'h00254; busy=1 for 16 cycles.
  - Only one conversion occurs.
- value=16'hC86C -> bcd=20'h51308. value=16'hFFFF -> bcd=20'h65535. value=16'h0000 -> bcd=20'h00000, done after 16 clocks.
- Back-to-back: convert 16'h0009 (bcd=20'h00009).
  - During SHIFT, change value to 16'h1234 and pulse init.
  - Required: result still 20'h00009, no restart.
  - A later init then yields 20'h04660.
- init held high for 40 cycles with value=16'h03E8:
  - Two conversions complete (done high one cycle each, 17 cycles apart).
  - bcd=20'h01000.
- Reset asserted (reset=0) at cycle 8 of a conversion of 16'hC86C:
  - bcd, done and busy are 0 immediately, without waiting for a clock.
  - After release, no done appears without a new init.
  - A fresh init converts correctly to 20'h51308.
